// File: rtl/fpga_exit_reporter.sv
// Board-side MCU exit reporter: on a rising exit_valid edge, prints "EXIT=XXXXXXXX\r\n"
// over an 8N1 UART and drives done/pass/fail/overrun status LEDs.
module fpga_exit_reporter #(
    parameter int unsigned CLK_FREQ_HZ = 15000000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic        done_led_o,
    output logic        pass_led_o,
    output logic        fail_led_o,
    output logic        overrun_o
);

    localparam int unsigned BAUD_DIV  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W     = $clog2(BAUD_DIV + 1);
    localparam int unsigned LAST_BYTE = 14;

    generate
        if (BAUD_DIV < 2) begin : g_baud_div_check
            $error("fpga_exit_reporter: BAUD_DIV must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [3:0]         r_byte_idx;
    logic [31:0]        r_value;
    logic               r_valid_q;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic               r_overrun;

    logic               w_edge;
    logic               w_bit_end;
    logic               w_final_end;
    logic               w_last_byte;
    logic [3:0]         w_nibble;
    logic [7:0]         w_hex;
    logic [7:0]         w_byte;
    logic               w_tx;

    assign w_edge      = exit_valid_i & ~r_valid_q;
    assign w_bit_end   = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign w_last_byte = (r_byte_idx == 4'(LAST_BYTE));
    // The final stop bit runs one extra FSM cycle so busy drops exactly as the registered tx line finishes it.
    assign w_final_end = (r_baud_cnt == CNT_W'(BAUD_DIV));

    // Nibble for the hex digit positions, MSB nibble first.
    always_comb begin
        w_nibble = 4'h0;
        case (r_byte_idx)
            4'd5:    w_nibble = r_value[31:28];
            4'd6:    w_nibble = r_value[27:24];
            4'd7:    w_nibble = r_value[23:20];
            4'd8:    w_nibble = r_value[19:16];
            4'd9:    w_nibble = r_value[15:12];
            4'd10:   w_nibble = r_value[11:8];
            4'd11:   w_nibble = r_value[7:4];
            4'd12:   w_nibble = r_value[3:0];
            default: w_nibble = 4'h0;
        endcase
    end

    assign w_hex = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                      : (8'h37 + {4'h0, w_nibble});

    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx)
            4'd0:    w_byte = 8'h45;
            4'd1:    w_byte = 8'h58;
            4'd2:    w_byte = 8'h49;
            4'd3:    w_byte = 8'h54;
            4'd4:    w_byte = 8'h3D;
            4'd13:   w_byte = 8'h0D;
            4'd14:   w_byte = 8'h0A;
            default: w_byte = w_hex;
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = w_byte[r_bit_idx];
            default: w_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_value    <= '0;
            r_valid_q  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_valid_q <= exit_valid_i;
            r_tx      <= w_tx;
            if (w_edge && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_value    <= exit_value_i;
                        r_byte_idx <= '0;
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (!w_last_byte && w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_byte_idx <= r_byte_idx + 4'd1;
                        r_state    <= S_START;
                    end else if (w_last_byte && w_final_end) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_pass     <= (r_value == 32'h0);
                        r_fail     <= (r_value != 32'h0);
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uart_tx_o  = r_tx;
    assign busy_o     = r_busy;
    assign done_led_o = r_done;
    assign pass_led_o = r_pass;
    assign fail_led_o = r_fail;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
// Directed self-checking bench for fpga_exit_reporter at BAUD_DIV=10; decodes the UART line
// from per-cycle samples and compares against hand-written expected strings.
module tb_fpga_exit_reporter;

    localparam int D     = 10;
    localparam int NSAMP = 150 * D;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] value;
    logic        tx;
    logic        busy;
    logic        done_led;
    logic        pass_led;
    logic        fail_led;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic       samp [NSAMP];
    logic [7:0] rx_b [15];
    int         lat;
    int         busy_cnt;
    int         nsamp;
    int         glitches;
    int         ferr;
    bit         cap_done;

    fpga_exit_reporter #(
        .CLK_FREQ_HZ(1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .exit_valid_i(valid),
        .exit_value_i(value),
        .uart_tx_o   (tx),
        .busy_o      (busy),
        .done_led_o  (done_led),
        .pass_led_o  (pass_led),
        .fail_led_o  (fail_led),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one report from the current negedge, sampling tx every negedge until busy falls.
    task automatic capture(input bit do_raise, input logic [31:0] val, input int drop_at,
                           input int raise_at, input logic [31:0] val2);
        int  n;
        bit  seen;
        logic [7:0] b;
        logic bv;
        int  base;
        n = 0; seen = 0; lat = -1; busy_cnt = 0; nsamp = 0; glitches = 0; ferr = 0;
        cap_done = 0;
        for (int i = 0; i < 15; i++) rx_b[i] = 8'h00;
        if (do_raise) begin
            valid = 1'b1;
            value = val;
        end
        while (!cap_done && n < 4000) begin
            @(negedge clk);
            n++;
            if (busy) begin
                busy_cnt++;
                seen = 1;
            end else if (seen) begin
                cap_done = 1;
            end
            if (lat < 0 && tx == 1'b0) lat = n;
            if (lat >= 0 && nsamp < NSAMP) begin
                samp[nsamp] = tx;
                nsamp++;
            end
            if (n == drop_at) valid = 1'b0;
            if (n == raise_at) begin
                valid = 1'b1;
                value = val2;
            end
        end
        check_eq("capture_finished", 32'(cap_done), 32'd1);
        if (nsamp == NSAMP) begin
            for (int by = 0; by < 15; by++) begin
                b = 8'h00;
                for (int j = 0; j < 10; j++) begin
                    base = by * 100 + j * D;
                    bv = samp[base + 5];
                    for (int c = 0; c < D; c++) if (samp[base + c] !== bv) glitches++;
                    if (j == 0 && bv !== 1'b0) ferr++;
                    if (j == 9 && bv !== 1'b1) ferr++;
                    if (j >= 1 && j <= 8) b[j-1] = bv;
                end
                rx_b[by] = b;
            end
        end
    endtask

    task automatic check_report(input string tag, input string exp);
        logic [7:0] e;
        check_eq({tag, "_tx_latency"}, 32'(lat), 32'd2);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd1501);
        check_eq({tag, "_samples"}, 32'(nsamp), 32'(NSAMP));
        check_eq({tag, "_bit_width_glitches"}, 32'(glitches), 32'd0);
        check_eq({tag, "_framing"}, 32'(ferr), 32'd0);
        for (int i = 0; i < 15; i++) begin
            e = exp[i];
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx_b[i]), 32'(e));
        end
        check_eq({tag, "_done"}, 32'(done_led), 32'd1);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    initial begin
        int extra;
        rst_n = 1'b0;
        valid = 1'b0;
        value = 32'h0;
        idle_cycles(3);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done_led), 32'd0);
        check_eq("rst_pass", 32'(pass_led), 32'd0);
        check_eq("rst_fail", 32'(fail_led), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle_cycles(3);

        // 1: zero value
        capture(1, 32'h0, 20, -1, 32'h0);
        check_report("t1", "EXIT=00000000\r\n");
        check_eq("t1_pass", 32'(pass_led), 32'd1);
        check_eq("t1_fail", 32'(fail_led), 32'd0);
        check_eq("t1_overrun", 32'(overrun), 32'd0);
        idle_cycles(5);

        // 2: one-cycle pulse
        capture(1, 32'hDEADBEEF, 1, -1, 32'h0);
        check_report("t2", "EXIT=DEADBEEF\r\n");
        check_eq("t2_pass", 32'(pass_led), 32'd0);
        check_eq("t2_fail", 32'(fail_led), 32'd1);
        idle_cycles(5);

        // 3: held level, value changes after latch
        capture(1, 32'h000000C3, -1, 100, 32'h5);
        check_report("t3", "EXIT=000000C3\r\n");
        extra = 0;
        for (int i = 0; i < 3500; i++) begin
            @(negedge clk);
            if (busy) extra++;
        end
        check_eq("t3_no_second_report", 32'(extra), 32'd0);
        check_eq("t3_overrun", 32'(overrun), 32'd0);
        valid = 1'b0;
        idle_cycles(5);

        // 4: re-edge during report
        capture(1, 32'h00001234, 395, 400, 32'h7);
        check_report("t4a", "EXIT=00001234\r\n");
        check_eq("t4a_overrun", 32'(overrun), 32'd1);
        valid = 1'b0;
        idle_cycles(3);
        capture(1, 32'h7, 20, -1, 32'h7);
        check_report("t4b", "EXIT=00000007\r\n");
        check_eq("t4b_fail", 32'(fail_led), 32'd1);
        check_eq("t4b_pass", 32'(pass_led), 32'd0);
        idle_cycles(5);

        // 5: reset while start bit of byte 3 is on the line
        valid = 1'b1;
        value = 32'hFFFFFFFF;
        for (int n = 1; n <= 305; n++) begin
            @(negedge clk);
            if (n == 5) valid = 1'b0;
        end
        check_eq("t5_tx_low_before_rst", 32'(tx), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t5_tx", 32'(tx), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_done", 32'(done_led), 32'd0);
        check_eq("t5_pass", 32'(pass_led), 32'd0);
        check_eq("t5_fail", 32'(fail_led), 32'd0);
        check_eq("t5_overrun", 32'(overrun), 32'd0);
        idle_cycles(3);
        check_eq("t5_tx_idle", 32'(tx), 32'd1);
        capture(1, 32'h0BADF00D, 20, -1, 32'h0);
        check_report("t5", "EXIT=0BADF00D\r\n");
        check_eq("t5_fail_after", 32'(fail_led), 32'd1);
        idle_cycles(5);

        // 6: valid already high at reset release
        rst_n = 1'b0;
        valid = 1'b1;
        value = 32'h000000A5;
        idle_cycles(3);
        check_eq("t6_busy_in_rst", 32'(busy), 32'd0);
        rst_n = 1'b1;
        capture(0, 32'h0, 20, -1, 32'h0);
        check_report("t6", "EXIT=000000A5\r\n");
        check_eq("t6_overrun", 32'(overrun), 32'd0);
        idle_cycles(5);

        // 7: edge on the same clock that busy falls is rejected
        capture(1, 32'h0, 20, 1501, 32'h9);
        check_report("t7", "EXIT=00000000\r\n");
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) extra++;
        end
        check_eq("t7_no_restart", 32'(extra), 32'd0);
        check_eq("t7_overrun", 32'(overrun), 32'd1);
        check_eq("t7_pass", 32'(pass_led), 32'd1);
        valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
